// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Multi-cycle fetch/decode/execute sequencer with gated write pulses
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int          PC_W    = 8,
    parameter int          IM_LAT  = 1,
    parameter int          DM_LAT  = 1,
    parameter logic [15:0] HALT_OP = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] im_addr,
    input  logic [15:0]     im_data,
    output logic [15:0]     instr,
    input  logic            cu_rb_we,
    input  logic            cu_dm_we,
    input  logic            cu_seg_we,
    input  logic            cu_led_we,
    input  logic            cu_branch,
    input  logic            branch_cond,
    input  logic [PC_W-1:0] branch_target,
    output logic            rb_we,
    output logic            dm_we,
    output logic            seg_we,
    output logic            led_we,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_IM = 3'd2,
        S_DECODE  = 3'd3,
        S_EXECUTE = 3'd4,
        S_MEM     = 3'd5,
        S_WB      = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [2:0] C_IM_LAT = 3'(IM_LAT);
    localparam logic [2:0] C_DM_LAT = 3'(DM_LAT);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] target_q;
    logic [15:0]     instr_q;
    logic [2:0]      cnt_q;
    logic            taken_q;
    logic            oneshot_q;
    logic            halted_q;
    logic            rb_we_q;
    logic            dm_we_q;
    logic            seg_we_q;
    logic            led_we_q;

    assign pc_d = taken_q ? target_q : pc_q + 1'b1;

    // Write pulses are registered so they are set only on the edge entering
    // MEM/WB and cleared by the async reset without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            target_q  <= '0;
            instr_q   <= '0;
            cnt_q     <= '0;
            taken_q   <= 1'b0;
            oneshot_q <= 1'b0;
            halted_q  <= 1'b0;
            rb_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            seg_we_q  <= 1'b0;
            led_we_q  <= 1'b0;
        end else begin
            rb_we_q  <= 1'b0;
            dm_we_q  <= 1'b0;
            seg_we_q <= 1'b0;
            led_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q   <= S_FETCH;
                        oneshot_q <= 1'b0;
                    end else if (step) begin
                        state_q   <= S_FETCH;
                        oneshot_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    cnt_q   <= C_IM_LAT;
                    state_q <= S_WAIT_IM;
                end
                S_WAIT_IM: begin
                    if (cnt_q <= 3'd1) begin
                        instr_q <= im_data;
                        state_q <= S_DECODE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_DECODE: begin
                    if (instr_q == HALT_OP) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    taken_q  <= cu_branch & branch_cond;
                    target_q <= branch_target;
                    if (cu_dm_we) begin
                        state_q <= S_MEM;
                        cnt_q   <= C_DM_LAT;
                        dm_we_q <= 1'b1;
                    end else begin
                        state_q  <= S_WB;
                        rb_we_q  <= cu_rb_we;
                        seg_we_q <= cu_seg_we;
                        led_we_q <= cu_led_we;
                    end
                end
                S_MEM: begin
                    if (cnt_q == 3'd0) begin
                        state_q  <= S_WB;
                        rb_we_q  <= cu_rb_we;
                        seg_we_q <= cu_seg_we;
                        led_we_q <= cu_led_we;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_WB: begin
                    pc_q <= pc_d;
                    if (run && !oneshot_q) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q   <= S_IDLE;
                        oneshot_q <= 1'b0;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign im_addr = pc_q;
    assign pc      = pc_q;
    assign instr   = instr_q;
    assign state   = state_q;
    assign halted  = halted_q;
    assign rb_we   = rb_we_q;
    assign dm_we   = dm_we_q;
    assign seg_we  = seg_we_q;
    assign led_we  = led_we_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Scoreboard bench for instr_sequencer (IM_LAT=1, DM_LAT=2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int PC_W   = 8;
    localparam int DM_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic            step;
    logic [PC_W-1:0] im_addr;
    logic [15:0]     im_data;
    logic [15:0]     instr;
    logic            cu_rb_we, cu_dm_we, cu_seg_we, cu_led_we, cu_branch;
    logic            branch_cond;
    logic [PC_W-1:0] branch_target;
    logic            rb_we, dm_we, seg_we, led_we;
    logic [PC_W-1:0] pc;
    logic [2:0]      state;
    logic            halted;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] nxt;
        logic       rb, dm, seg, led;
        int         len;
    } exp_t;
    exp_t sbq[$];

    instr_sequencer #(
        .PC_W   (PC_W),
        .IM_LAT (1),
        .DM_LAT (DM_LAT),
        .HALT_OP(16'hFFFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .step         (step),
        .im_addr      (im_addr),
        .im_data      (im_data),
        .instr        (instr),
        .cu_rb_we     (cu_rb_we),
        .cu_dm_we     (cu_dm_we),
        .cu_seg_we    (cu_seg_we),
        .cu_led_we    (cu_led_we),
        .cu_branch    (cu_branch),
        .branch_cond  (branch_cond),
        .branch_target(branch_target),
        .rb_we        (rb_we),
        .dm_we        (dm_we),
        .seg_we       (seg_we),
        .led_we       (led_we),
        .pc           (pc),
        .state        (state),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // One-cycle instruction memory and a toy decoder: bit0 rb, bit1 store,
    // bit2 seg, bit3 led, bit4 branch, bits15:8 branch target.
    always @(posedge clk) im_data <= mem[im_addr];
    assign cu_rb_we      = instr[0];
    assign cu_dm_we      = instr[1];
    assign cu_seg_we     = instr[2];
    assign cu_led_we     = instr[3];
    assign cu_branch     = instr[4];
    assign branch_target = instr[15:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops one scoreboard entry per WB cycle
    int         len    = 0;
    int         dm_cnt = 0;
    int         dm_pos = 0;
    logic       pend   = 1'b0;
    logic [7:0] exp_next;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend   = 1'b0;
            len    = 0;
            dm_cnt = 0;
            dm_pos = 0;
        end else begin
            if (pend) begin
                chk("next_pc", 32'(pc), 32'(exp_next));
                pend = 1'b0;
            end
            if (state == 3'd1) begin
                len = 1; dm_cnt = 0; dm_pos = 0;
            end else begin
                len++;
            end
            if (dm_we) begin
                dm_cnt++;
                dm_pos = len;
            end
            if (state != 3'd5 && state != 3'd6)
                chk("pulse_outside", 32'({rb_we, dm_we, seg_we, led_we}), 32'd0);
            if (state == 3'd5)
                chk("mem_reg_pulses", 32'({rb_we, seg_we, led_we}), 32'd0);
            if (state == 3'd6) begin
                checks++;
                assert (sbq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_wb observed=pc%0h expected=no_wb", pc);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("wb_pc",     32'(pc), 32'(e.pc));
                    chk("wb_pulses", 32'({rb_we, seg_we, led_we}), 32'({e.rb, e.seg, e.led}));
                    chk("dm_count",  32'(dm_cnt), 32'(e.dm ? 1 : 0));
                    chk("dm_pos",    32'(dm_pos), 32'(e.dm ? 5 : 0));
                    chk("instr_len", 32'(len), 32'(e.len));
                    pend     = 1'b1;
                    exp_next = e.nxt;
                end
            end
        end
    end

    task automatic push_instrs(input int n, input logic [7:0] start, input logic cond);
        logic [7:0]  p;
        logic [15:0] w;
        exp_t        e;
        p = start;
        for (int i = 0; i < n; i++) begin
            w     = mem[p];
            e.pc  = p;
            e.rb  = w[0];
            e.dm  = w[1];
            e.seg = w[2];
            e.led = w[3];
            e.len = w[1] ? 6 + DM_LAT : 5;
            e.nxt = (w[4] && cond) ? w[15:8] : p + 8'd1;
            sbq.push_back(e);
            p = e.nxt;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== s && n < budget);
        checks++;
        assert (state === s) else begin
            errors++;
            $error("FAIL %s timeout observed_state=%0d expected_state=%0d", tag, state, s);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Execute n instructions in free-run, dropping run during the last one.
    task automatic run_n(input int n, input logic with_step);
        run  = 1'b1;
        step = with_step;
        @(negedge clk);
        step = 1'b0;
        for (int i = 1; i < n; i++) wait_state(3'd6, 20, "run_wb");
        @(negedge clk);
        run = 1'b0;
        wait_state(3'd6, 20, "last_wb");
        wait_state(3'd0, 5, "back_idle");
    endtask

    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        branch_cond = 1'b0;
        clear_mem();

        // Reset values, then idle with run=0
        repeat (2) @(negedge clk);
        chk("rst_state",  32'(state), 32'd0);
        chk("rst_pc",     32'(pc), 32'd0);
        chk("rst_instr",  32'(instr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pulses", 32'({rb_we, dm_we, seg_we, led_we}), 32'd0);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_pc",    32'(pc), 32'd0);

        // Async reset during WB drops rb_we before the next edge
        mem[0] = 16'h0001;
        push_instrs(1, 8'h00, 1'b0);
        run = 1'b1;
        wait_state(3'd6, 20, "wb_for_reset");
        chk("wb_rb_high", 32'(rb_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rb_drop",    32'(rb_we), 32'd0);
        chk("async_state_idle", 32'(state), 32'd0);
        chk("async_pc",         32'(pc), 32'd0);
        run = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // NOP stream across the pc wrap
        clear_mem();
        do_reset();
        push_instrs(257, 8'h00, 1'b0);
        run_n(257, 1'b0);
        chk("nop_wrap_pc", 32'(pc), 32'h01);

        // Register, seg and LED writes at distinct pcs
        do_reset();
        mem[2] = 16'h0004;
        mem[3] = 16'h0009;
        push_instrs(5, 8'h00, 1'b0);
        run_n(5, 1'b0);
        chk("wr_pc", 32'(pc), 32'h05);

        // Stores: without and with a register write
        clear_mem();
        do_reset();
        mem[0] = 16'h0002;
        mem[1] = 16'h0003;
        push_instrs(2, 8'h00, 1'b0);
        run_n(2, 1'b0);
        chk("store_pc", 32'(pc), 32'h02);

        // Branch taken to 0x20, self-loop there; step together with run
        clear_mem();
        do_reset();
        branch_cond = 1'b1;
        mem[0]      = 16'h2010;
        mem[8'h20]  = 16'h2010;
        push_instrs(2, 8'h00, 1'b1);
        run_n(2, 1'b1);
        chk("branch_pc", 32'(pc), 32'h20);

        // Not taken, executed by a single step
        branch_cond = 1'b0;
        push_instrs(1, 8'h20, 1'b0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_state(3'd6, 20, "step_wb");
        wait_state(3'd0, 5, "step_idle");
        chk("not_taken_pc", 32'(pc), 32'h21);

        // Step during EXECUTE is ignored
        push_instrs(1, 8'h21, 1'b0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_state(3'd4, 20, "step_exec");
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_state(3'd0, 20, "step2_idle");
        repeat (10) @(negedge clk);
        chk("step_ignored_state", 32'(state), 32'd0);
        chk("step_ignored_pc",    32'(pc), 32'h22);

        // HALT freezes until reset
        clear_mem();
        do_reset();
        mem[1] = 16'hFFFF;
        push_instrs(1, 8'h00, 1'b0);
        run = 1'b1;
        wait_state(3'd7, 30, "halt_entry");
        chk("halted_flag", 32'(halted), 32'd1);
        chk("halt_pc",     32'(pc), 32'h01);
        chk("halt_instr",  32'(instr), 32'hFFFF);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (20) @(negedge clk);
        chk("halt_stay_state", 32'(state), 32'd7);
        chk("halt_stay_pc",    32'(pc), 32'h01);
        do_reset();
        chk("halt_clear",      32'(halted), 32'd0);
        chk("halt_exit_state", 32'(state), 32'd0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
